// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS control FSM
//
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// steering one shared ALU and one unified memory port (mem_req/mem_ready).
//
// Ports:
//   clk, rstn        clock (rising edge), synchronous active-low reset
//   op, funct        instruction register fields
//   zero             ALU zero flag (branch condition)
//   mem_ready        memory finishes the current access this cycle
//   mem_req, iord, memwrite               memory port control
//   irwrite, pc_en, pcsrc                 instruction register / PC control
//   alusrca, alusrcb, aluop, sextend      ALU operand and operation select
//   regdst, memtoreg, regwrite            register file write control
//   retire           one-cycle pulse when an instruction completes
//   illegal          high while trapped on an unsupported instruction
//   state            current state code (debug)

module multicycle_controller #(
  parameter int MEM_WAIT_EN = 1,
  parameter int BNE_EN      = 1,
  parameter int ALUOP_W     = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pc_en,
  output logic [1:0]         pcsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [ALUOP_W-1:0] aluop,
  output logic               sextend,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               retire,
  output logic               illegal,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b1110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t     st_q, st_d;
  logic       rdy;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic [3:0] alu4;
  logic       mem_req_c, memwrite_c, irwrite_c, pc_en_c, regwrite_c, retire_c;

  assign rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  // R-type funct decode: legality and ALU operation.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b100110: funct_alu = ALU_XOR;
      6'b100111: funct_alu = ALU_NOR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) st_q <= S_FETCH;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d       = st_q;
    mem_req_c  = 1'b0;
    iord       = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    pc_en_c    = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alu4       = ALU_ADD;
    sextend    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_c = 1'b0;
    retire_c   = 1'b0;
    illegal    = 1'b0;
    case (st_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alusrcb   = 2'b01;
        irwrite_c = rdy;
        pc_en_c   = rdy;
        if (rdy) st_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alusrcb = 2'b11;
        sextend = 1'b1;
        case (op)
          OP_LW, OP_SW:                              st_d = S_MEMADR;
          OP_RTYPE:                                  st_d = funct_ok ? S_RTEXEC : S_TRAP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: st_d = S_IMMEXEC;
          OP_BEQ:                                    st_d = S_BRANCH;
          OP_BNE:                                    st_d = (BNE_EN != 0) ? S_BRANCH : S_TRAP;
          OP_J:                                      st_d = S_JUMP;
          default:                                   st_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        sextend = 1'b1;
        st_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        if (rdy) st_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 1'b1;
        retire_c   = 1'b1;
        st_d       = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c  = 1'b1;
        iord       = 1'b1;
        memwrite_c = 1'b1;
        retire_c   = rdy;
        if (rdy) st_d = S_FETCH;
      end
      S_RTEXEC: begin
        alusrca = 1'b1;
        alu4    = funct_alu;
        st_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst     = 1'b1;
        retire_c   = 1'b1;
        st_d       = S_FETCH;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        alu4     = ALU_SUB;
        pcsrc    = 2'b01;
        pc_en_c  = (BNE_EN != 0 && op == OP_BNE) ? ~zero : zero;
        retire_c = 1'b1;
        st_d     = S_FETCH;
      end
      S_IMMEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_SLTI: begin alu4 = ALU_SLT; sextend = 1'b1; end
          OP_ANDI: alu4 = ALU_AND;
          OP_ORI:  alu4 = ALU_OR;
          OP_XORI: alu4 = ALU_XOR;
          default: begin alu4 = ALU_ADD; sextend = 1'b1; end
        endcase
        st_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite_c = 1'b1;
        retire_c   = 1'b1;
        st_d       = S_FETCH;
      end
      S_JUMP: begin
        pcsrc    = 2'b10;
        pc_en_c  = 1'b1;
        retire_c = 1'b1;
        st_d     = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: st_d = S_TRAP;
    endcase
  end

  // Strobes are gated by rstn so an access in flight is abandoned immediately.
  assign mem_req  = rstn & mem_req_c;
  assign memwrite = rstn & memwrite_c;
  assign irwrite  = rstn & irwrite_c;
  assign pc_en    = rstn & pc_en_c;
  assign regwrite = rstn & regwrite_c;
  assign retire   = rstn & retire_c;
  assign aluop    = ALUOP_W'(alu4);
  assign state    = st_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [5:0] op = 6'b0;
  logic [5:0] funct = 6'b100000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic mem_req, iord, memwrite, irwrite, pc_en, alusrca, sextend, regdst, memtoreg, regwrite, retire, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [3:0] aluop, state;

  logic b_mem_req, b_iord, b_memwrite, b_irwrite, b_pc_en, b_alusrca, b_sextend, b_regdst, b_memtoreg, b_regwrite, b_retire, b_illegal;
  logic [1:0] b_pcsrc, b_alusrcb;
  logic [3:0] b_aluop, b_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_EN(1), .BNE_EN(1), .ALUOP_W(4)) dut (
    .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pc_en(pc_en),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .sextend(sextend),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .retire(retire),
    .illegal(illegal), .state(state));

  multicycle_controller #(.MEM_WAIT_EN(1), .BNE_EN(0), .ALUOP_W(4)) dut_nobne (
    .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite), .pc_en(b_pc_en),
    .pcsrc(b_pcsrc), .alusrca(b_alusrca), .alusrcb(b_alusrcb), .aluop(b_aluop), .sextend(b_sextend),
    .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite), .retire(b_retire),
    .illegal(b_illegal), .state(b_state));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    mem_ready = 1'b0;
    rstn = 1'b0;
    step();
    step();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req_forced got %0b exp 0", mem_req); end
    rstn = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req got %0b exp 1", mem_req); end
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL fetch_pc_en_wait got %0b exp 0", pc_en); end
    checks++; if (alusrcb !== 2'b01 || aluop !== 4'b0110) begin errors++; $display("FAIL fetch_alu got %0b/%0b exp 01/0110", alusrcb, aluop); end
    step();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL fetch_hold got %0d exp 0", state); end
    mem_ready = 1'b1;
    #1;
    checks++; if (pc_en !== 1'b1 || irwrite !== 1'b1) begin errors++; $display("FAIL fetch_ready got pc_en %0b irwrite %0b exp 1 1", pc_en, irwrite); end
  endtask

  task automatic test_lw();
    int retires;
    op = 6'b100011;
    mem_ready = 1'b1;
    do_reset();
    retires = 0;
    if (retire === 1'b1) retires++;
    step();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL lw_decode got %0d exp 1", state); end
    if (retire === 1'b1) retires++;
    step();
    checks++; if (state !== 4'd2 || alusrcb !== 2'b10 || alusrca !== 1'b1) begin errors++; $display("FAIL lw_memadr got st %0d srcb %0b exp 2 10", state, alusrcb); end
    if (retire === 1'b1) retires++;
    step();
    checks++; if (state !== 4'd3 || mem_req !== 1'b1 || iord !== 1'b1) begin errors++; $display("FAIL lw_memrd got st %0d req %0b iord %0b exp 3 1 1", state, mem_req, iord); end
    if (retire === 1'b1) retires++;
    step();
    checks++; if (state !== 4'd4 || regwrite !== 1'b1 || memtoreg !== 1'b1 || regdst !== 1'b0) begin errors++; $display("FAIL lw_memwb got st %0d rw %0b m2r %0b exp 4 1 1", state, regwrite, memtoreg); end
    if (retire === 1'b1) retires++;
    step();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_back_fetch got %0d exp 0", state); end
    checks++; if (retires != 1) begin errors++; $display("FAIL lw_retire_count got %0d exp 1", retires); end
  endtask

  task automatic test_sw_wait();
    int wr_cycles;
    int retires;
    op = 6'b101011;
    mem_ready = 1'b1;
    do_reset();
    step();
    step();
    step();
    checks++; if (state !== 4'd5) begin errors++; $display("FAIL sw_memwr got %0d exp 5", state); end
    wr_cycles = 0;
    retires = 0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (memwrite === 1'b1 && state === 4'd5) wr_cycles++;
      if (retire === 1'b1) retires++;
      step();
    end
    mem_ready = 1'b1;
    #1;
    if (memwrite === 1'b1 && state === 4'd5) wr_cycles++;
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL sw_retire_on_ready got %0b exp 1", retire); end
    checks++; if (retires != 0) begin errors++; $display("FAIL sw_retire_while_wait got %0d exp 0", retires); end
    step();
    checks++; if (wr_cycles != 4) begin errors++; $display("FAIL sw_memwrite_cycles got %0d exp 4", wr_cycles); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_back_fetch got %0d exp 0", state); end
  endtask

  task automatic test_branch();
    op = 6'b000100;
    zero = 1'b1;
    mem_ready = 1'b1;
    do_reset();
    step();
    step();
    checks++; if (state !== 4'd8 || pc_en !== 1'b1 || pcsrc !== 2'b01 || aluop !== 4'b1110) begin errors++; $display("FAIL beq_taken got st %0d pc_en %0b pcsrc %0b aluop %0b exp 8 1 01 1110", state, pc_en, pcsrc, aluop); end
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL beq_retire got %0b exp 1", retire); end
    op = 6'b000101;
    do_reset();
    step();
    step();
    checks++; if (state !== 4'd8 || pc_en !== 1'b0) begin errors++; $display("FAIL bne_zero got st %0d pc_en %0b exp 8 0", state, pc_en); end
    zero = 1'b0;
    #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL bne_nonzero got %0b exp 1", pc_en); end
    step();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL branch_back_fetch got %0d exp 0", state); end
  endtask

  task automatic test_bne_disabled();
    op = 6'b000101;
    zero = 1'b1;
    mem_ready = 1'b1;
    do_reset();
    step();
    step();
    checks++; if (b_state !== 4'd12 || b_illegal !== 1'b1) begin errors++; $display("FAIL bne_disabled_trap got st %0d illegal %0b exp 12 1", b_state, b_illegal); end
  endtask

  task automatic test_rtype();
    op = 6'b000000;
    funct = 6'b100010;
    mem_ready = 1'b1;
    do_reset();
    step();
    step();
    checks++; if (state !== 4'd6 || aluop !== 4'b1110 || alusrcb !== 2'b00) begin errors++; $display("FAIL rt_sub got st %0d aluop %0b exp 6 1110", state, aluop); end
    step();
    checks++; if (state !== 4'd7 || regdst !== 1'b1 || regwrite !== 1'b1) begin errors++; $display("FAIL rt_aluwb got st %0d regdst %0b exp 7 1", state, regdst); end
    funct = 6'b000000;
    do_reset();
    step();
    step();
    checks++; if (state !== 4'd12 || illegal !== 1'b1) begin errors++; $display("FAIL rt_bad_trap got st %0d illegal %0b exp 12 1", state, illegal); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (state !== 4'd12 || mem_req !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL trap_sticky got st %0d req %0b exp 12 0", state, mem_req); end
    do_reset();
    checks++; if (state !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL trap_reset got st %0d illegal %0b exp 0 0", state, illegal); end
    funct = 6'b100000;
  endtask

  task automatic test_immediate();
    op = 6'b001100;
    mem_ready = 1'b1;
    do_reset();
    step();
    step();
    checks++; if (state !== 4'd9 || sextend !== 1'b0 || aluop !== 4'b0000) begin errors++; $display("FAIL andi got st %0d sext %0b aluop %0b exp 9 0 0000", state, sextend, aluop); end
    step();
    checks++; if (state !== 4'd10 || regwrite !== 1'b1 || regdst !== 1'b0) begin errors++; $display("FAIL immwb got st %0d rw %0b exp 10 1", state, regwrite); end
    op = 6'b001000;
    do_reset();
    step();
    step();
    checks++; if (state !== 4'd9 || sextend !== 1'b1 || aluop !== 4'b0110) begin errors++; $display("FAIL addi got st %0d sext %0b aluop %0b exp 9 1 0110", state, sextend, aluop); end
    op = 6'b001010;
    do_reset();
    step();
    step();
    checks++; if (aluop !== 4'b1111 || sextend !== 1'b1) begin errors++; $display("FAIL slti got aluop %0b sext %0b exp 1111 1", aluop, sextend); end
  endtask

  task automatic test_jump();
    op = 6'b000010;
    mem_ready = 1'b1;
    do_reset();
    step();
    step();
    checks++; if (state !== 4'd11 || pcsrc !== 2'b10 || pc_en !== 1'b1 || retire !== 1'b1) begin errors++; $display("FAIL jump got st %0d pcsrc %0b pc_en %0b exp 11 10 1", state, pcsrc, pc_en); end
  endtask

  task automatic test_reset_in_memrd();
    op = 6'b100011;
    mem_ready = 1'b1;
    do_reset();
    step();
    step();
    mem_ready = 1'b0;
    step();
    checks++; if (state !== 4'd3 || mem_req !== 1'b1) begin errors++; $display("FAIL memrd_wait got st %0d req %0b exp 3 1", state, mem_req); end
    rstn = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || regwrite !== 1'b0) begin errors++; $display("FAIL memrd_reset_gate got req %0b rw %0b exp 0 0", mem_req, regwrite); end
    mem_ready = 1'b1;
    step();
    checks++; if (state !== 4'd0 || regwrite !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("FAIL memrd_reset_fetch got st %0d rw %0b exp 0 0", state, regwrite); end
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch();
    test_bne_disabled();
    test_rtype();
    test_immediate();
    test_jump();
    test_reset_in_memrd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle MIPS datapath; successor to the single-cycle decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives one shared ALU and one unified memory port with a request/ready handshake.
- Adds BNE, an illegal-instruction trap and a retire pulse.
- Same ALU encoding as the single-cycle core: ADD 0110, SUB 1110, AND 0000, OR 0001, XOR 0010, NOR 0011, SLT 1111.

Parameters:
- MEM_WAIT_EN, 1: 1 = honour mem_ready; 0 = mem_ready ignored, treated as 1.
- BNE_EN, 1: 1 = decode BNE (op 000101); 0 = BNE traps.
- ALUOP_W, 4: aluop width; encodings occupy the low 4 bits, upper bits 0.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- op  in  6  opcode from instruction register
- funct  in  6  funct field from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  write strobe, valid with mem_req
- irwrite  out  1  load instruction register
- pc_en  out  1  PC load enable
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alusrca  out  1  0 = PC, 1 = regA
- alusrcb  out  2  00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2
- aluop  out  ALUOP_W  ALU operation
- sextend  out  1  1 = sign-extend imm, 0 = zero-extend
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = memory data, 0 = ALUOut
- regwrite  out  1  register file write
- retire  out  1  one-cycle pulse on instruction completion
- illegal  out  1  high while in TRAP
- state  out  4  current state code (debug)

Behaviour:
- Moore FSM; all outputs decoded from state (plus zero/mem_ready where stated). Defaults: all 0, aluop = ADD.
- Reset: any edge with rstn=0 sets state FETCH (0). While rstn=0, mem_req, memwrite, irwrite, pc_en, regwrite and retire are forced 0 combinationally. Reset mid-access abandons the access with no PC/register update.
- Wait rule: "rdy" = mem_ready if MEM_WAIT_EN, else 1.
- FETCH (0): mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00; irwrite=pc_en=rdy. Next state is DECODE if rdy, else stay.
- DECODE (1): alusrca=0, alusrcb=11, sextend=1, aluop=ADD (branch target into ALUOut). Next state by op:
  - LW 100011 or SW 101011 -> MEMADR.
  - R-type 000000 with supported funct (100000, 100010, 100100, 100101, 100110, 100111, 101010) -> RTEXEC; other funct -> TRAP.
  - ADDI, SLTI, ANDI, ORI, XORI -> IMMEXEC.
  - BEQ, or BNE when BNE_EN=1 -> BRANCH.
  - J 000010 -> JUMP.
  - Anything else -> TRAP.
- MEMADR (2): alusrca=1, alusrcb=10, sextend=1, ADD. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD (3): mem_req=1, iord=1. Next: MEMWB on rdy, else stay.
- MEMWB (4): regwrite=1, memtoreg=1, regdst=0, retire=1. Next: FETCH.
- MEMWR (5): mem_req=1, iord=1, memwrite=1; retire=rdy. Next: FETCH on rdy, else stay.
- RTEXEC (6): alusrca=1, alusrcb=00, aluop from funct. Next: ALUWB.
- ALUWB (7): regwrite=1, regdst=1, memtoreg=0, retire=1. Next: FETCH.
- BRANCH (8): alusrca=1, alusrcb=00, SUB, pcsrc=01; pc_en=zero for BEQ, ~zero for BNE; retire=1. Next: FETCH.
- IMMEXEC (9): alusrca=1, alusrcb=10. ADDI: ADD, sextend=1. SLTI: SLT, sextend=1. ANDI/ORI/XORI: AND/OR/XOR, sextend=0. Next: IMMWB.
- IMMWB (10): regwrite=1, regdst=0, memtoreg=0, retire=1. Next: FETCH.
- JUMP (11): pcsrc=10, pc_en=1, retire=1. Next: FETCH.
- TRAP (12): illegal=1, all strobes 0; held until reset.
- Codes 13-15 unreachable; if entered, next state is TRAP.
- op/funct are sampled every cycle from the instruction register, which is stable after FETCH.
- No memory request is ever issued outside states 0, 3 and 5.

Test Plan:
- Reset with rstn=0 for 2 edges, then release -> state=0, mem_req=1, pc_en=0 until mem_ready=1.
- LW with mem_ready=1 always -> states 0,1,2,3,4; regwrite+memtoreg in cycle 5; retire once.
- SW with mem_ready low 3 cycles in MEMWR -> memwrite held 4 cycles; retire only on the ready cycle; then FETCH.
- BEQ with zero=1 -> pc_en=1, pcsrc=01 in BRANCH. BNE with zero=1 -> pc_en=0. BNE with BNE_EN=0 -> TRAP, illegal=1.
- R-type funct 100010 -> aluop 1110 in RTEXEC, regdst=1 in ALUWB. funct 000000 -> TRAP, sticky until rstn=0.
- ANDI -> sextend=0, aluop 0000. ADDI -> sextend=1, aluop 0110. Reset asserted in MEMRD -> no regwrite, FETCH on next edge.
